// File: rtl/mul_schedule_gen_pkg.sv
// Shared types, defaults and beat-count helpers for the limb multiply schedule generator.
package mul_schedule_gen_pkg;

    localparam int unsigned FE_NLIMBS = 5;

    localparam logic [1:0] MUL_MODE_ROW = 2'd0;
    localparam logic [1:0] MUL_MODE_COL = 2'd1;
    localparam logic [1:0] MUL_MODE_SQR = 2'd2;
    localparam logic [1:0] MUL_MODE_RSV = 2'd3;

    // Beats in a full N x N product (ROW and COL orderings).
    function automatic int unsigned beats_full(input int unsigned n);
        return n * n;
    endfunction

    // Beats in a squaring schedule (upper triangle including diagonal).
    function automatic int unsigned beats_sqr(input int unsigned n);
        return (n * (n + 1)) / 2;
    endfunction

endpackage

// File: rtl/mul_schedule_gen_if.sv
// Beat stream from the schedule generator to the limb MAC datapath.
interface mul_schedule_gen_if
    import mul_schedule_gen_pkg::*;
#(
    parameter int unsigned IDX_W = $clog2(FE_NLIMBS),
    parameter int unsigned COL_W = $clog2(2 * FE_NLIMBS - 1)
);
    logic             o_valid;
    logic             o_ready;
    logic [IDX_W-1:0] i_out;
    logic [IDX_W-1:0] j_out;
    logic [COL_W-1:0] col_out;
    logic             dbl_out;
    logic             col_last;
    logic             o_last;

    modport master (
        output o_valid, i_out, j_out, col_out, dbl_out, col_last, o_last,
        input  o_ready
    );

    modport slave (
        input  o_valid, i_out, j_out, col_out, dbl_out, col_last, o_last,
        output o_ready
    );
endinterface

// File: rtl/mul_schedule_gen_step.sv
// Combinational successor function: given the current beat, produce the next beat
// and the column-end / final-beat flags that belong to that next beat.
module mul_schedule_gen_step
    import mul_schedule_gen_pkg::*;
#(
    parameter int unsigned NLIMBS = FE_NLIMBS,
    parameter int unsigned IDX_W  = $clog2(NLIMBS),
    parameter int unsigned COL_W  = $clog2(2 * NLIMBS - 1)
) (
    input  logic [1:0]       i_mode,
    input  logic [IDX_W-1:0] i_i,
    input  logic [IDX_W-1:0] i_j,
    input  logic [COL_W-1:0] i_col,
    output logic [IDX_W-1:0] o_i,
    output logic [IDX_W-1:0] o_j,
    output logic [COL_W-1:0] o_col,
    output logic             o_col_last,
    output logic             o_last
);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NLIMBS - 1);
    localparam logic [COL_W-1:0] COL_NM1 = COL_W'(NLIMBS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(2 * NLIMBS - 2);

    logic [COL_W-1:0] w_c1;
    logic [COL_W-1:0] w_lo;

    // True when (a, b) is the last beat of its row (ROW) or column (COL/SQR).
    function automatic logic col_end(input logic [1:0] m, input logic [IDX_W-1:0] a,
                                     input logic [IDX_W-1:0] b);
        case (m)
            MUL_MODE_ROW: return b == IDX_MAX;
            MUL_MODE_SQR: return (b == a) || (b == a + IDX_W'(1));
            default:      return (a == IDX_MAX) || (b == '0);
        endcase
    endfunction

    // Advance along the row, or step down the anti-diagonal and wrap to the next column.
    always_comb begin
        w_c1       = i_col + COL_W'(1);
        w_lo       = (w_c1 > COL_NM1) ? (w_c1 - COL_NM1) : '0;
        o_i        = i_i;
        o_j        = i_j;
        o_col      = i_col;
        o_col_last = 1'b0;
        o_last     = 1'b0;
        if (i_mode == MUL_MODE_ROW) begin
            if (i_j == IDX_MAX) begin
                o_i = i_i + IDX_W'(1);
                o_j = '0;
            end else begin
                o_j = i_j + IDX_W'(1);
            end
            o_col      = COL_W'(o_i) + COL_W'(o_j);
            o_col_last = col_end(i_mode, o_i, o_j);
            o_last     = o_col_last && (o_i == IDX_MAX);
        end else if (i_mode != MUL_MODE_RSV) begin
            if (col_end(i_mode, i_i, i_j)) begin
                o_col = w_c1;
                o_i   = IDX_W'(w_lo);
                o_j   = IDX_W'(w_c1 - w_lo);
            end else begin
                o_i = i_i + IDX_W'(1);
                o_j = i_j - IDX_W'(1);
            end
            o_col_last = col_end(i_mode, o_i, o_j);
            o_last     = (o_col == COL_MAX);
        end
    end

endmodule

// File: rtl/mul_schedule_gen.sv
// Schedule generator for schoolbook limb multiplication: FSM, beat registers, handshake.
module mul_schedule_gen
    import mul_schedule_gen_pkg::*;
#(
    parameter int unsigned NLIMBS = FE_NLIMBS,
    parameter int unsigned IDX_W  = $clog2(NLIMBS),
    parameter int unsigned COL_W  = $clog2(2 * NLIMBS - 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    mul_schedule_gen_if.master beat
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_load;
    logic             w_adv;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic [1:0]       r_mode;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [COL_W-1:0] r_col;
    logic             r_dbl;
    logic             r_col_last;
    logic             r_last;
    logic             r_done;
    logic             r_err;
    logic [IDX_W-1:0] w_ni;
    logic [IDX_W-1:0] w_nj;
    logic [COL_W-1:0] w_ncol;
    logic             w_ncol_last;
    logic             w_nlast;

    mul_schedule_gen_step #(
        .NLIMBS (NLIMBS),
        .IDX_W  (IDX_W),
        .COL_W  (COL_W)
    ) u_step (
        .i_mode     (r_mode),
        .i_i        (r_i),
        .i_j        (r_j),
        .i_col      (r_col),
        .o_i        (w_ni),
        .o_j        (w_nj),
        .o_col      (w_ncol),
        .o_col_last (w_ncol_last),
        .o_last     (w_nlast)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and beat-register control; abort outranks both start and handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (mode == MUL_MODE_RSV) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_load      = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (beat.o_ready) begin
                    if (r_last) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat registers: load beat (0,0) on start, advance on each accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MUL_MODE_ROW;
            r_i        <= '0;
            r_j        <= '0;
            r_col      <= '0;
            r_dbl      <= 1'b0;
            r_col_last <= 1'b0;
            r_last     <= 1'b0;
        end else if (w_load) begin
            r_mode     <= mode;
            r_i        <= '0;
            r_j        <= '0;
            r_col      <= '0;
            r_dbl      <= 1'b0;
            r_col_last <= (mode != MUL_MODE_ROW);
            r_last     <= 1'b0;
        end else if (w_adv) begin
            r_i        <= w_ni;
            r_j        <= w_nj;
            r_col      <= w_ncol;
            r_dbl      <= (r_mode == MUL_MODE_SQR) && (w_ni != w_nj);
            r_col_last <= w_ncol_last;
            r_last     <= w_nlast;
        end
    end

    // One-cycle completion and illegal-mode pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign busy          = r_state;
    assign done          = r_done;
    assign err           = r_err;
    assign beat.o_valid  = r_state;
    assign beat.i_out    = r_i;
    assign beat.j_out    = r_j;
    assign beat.col_out  = r_col;
    assign beat.dbl_out  = r_dbl;
    assign beat.col_last = r_col_last;
    assign beat.o_last   = r_last;

endmodule
